// File: rtl/tick_scheduler.sv
// tick_scheduler
//   Multi-channel periodic enable generator. A free-running cycle counter runs
//   alongside NCH independent channel counters; each enabled channel emits a
//   one-cycle registered tick every period[i] clock cycles. Sticky pending and
//   overrun flags let a consumer acknowledge ticks and detect missed ones.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   cfg_we      configuration write strobe
//   cfg_addr    channel index of the write; indices >= NCH are ignored
//   cfg_period  tick period in clk cycles (0 = channel stopped)
//   cfg_en      channel enable written together with the period
//   pause       global freeze of all channel counters (free_cnt keeps running)
//   ack         per-channel acknowledge, clears pending
//   tick        one-cycle registered strobe per channel
//   pending     sticky: a tick occurred and has not been acknowledged
//   overrun     sticky: a tick occurred while pending was still set
//   free_cnt    free-running cycle counter, wraps at 2^CW
module tick_scheduler #(
   parameter int NCH = 4,
   parameter int AW  = 2,
   parameter int CW  = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cfg_we,
   input  logic [AW-1:0]   cfg_addr,
   input  logic [CW-1:0]   cfg_period,
   input  logic            cfg_en,
   input  logic            pause,
   input  logic [NCH-1:0]  ack,
   output logic [NCH-1:0]  tick,
   output logic [NCH-1:0]  pending,
   output logic [NCH-1:0]  overrun,
   output logic [CW-1:0]   free_cnt
);

   logic [CW-1:0]  period [NCH];
   logic [CW-1:0]  cnt    [NCH];
   logic [NCH-1:0] en;

   logic [NCH-1:0] sel;
   logic [NCH-1:0] active;
   logic [NCH-1:0] wrap;

   // Addresses >= NCH have no matching channel, so such writes fall away.
   // wrap is only evaluated with period != 0, so period-1 never underflows.
   always_comb begin
      sel    = '0;
      active = '0;
      wrap   = '0;
      for (int i = 0; i < NCH; i++) begin
         sel[i]    = cfg_we && (cfg_addr == AW'(i));
         active[i] = en[i] && (period[i] != '0) && !pause;
         wrap[i]   = active[i] && (cnt[i] == period[i] - CW'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         free_cnt <= '0;
         en       <= '0;
         tick     <= '0;
         pending  <= '0;
         overrun  <= '0;
         for (int i = 0; i < NCH; i++) begin
            period[i] <= '0;
            cnt[i]    <= '0;
         end
      end else begin
         free_cnt <= free_cnt + CW'(1);
         for (int i = 0; i < NCH; i++) begin
            if (sel[i]) begin
               // A config write restarts the channel phase and clears its flags,
               // overriding any wrap or ack on the same edge.
               period[i]  <= cfg_period;
               en[i]      <= cfg_en;
               cnt[i]     <= '0;
               tick[i]    <= 1'b0;
               pending[i] <= 1'b0;
               overrun[i] <= 1'b0;
            end else begin
               if (active[i])
                  cnt[i] <= wrap[i] ? '0 : cnt[i] + CW'(1);
               tick[i] <= wrap[i];
               // A tick on the same edge as an ack keeps pending set and is
               // not an overrun: the ack covered the previous tick.
               if (wrap[i]) begin
                  pending[i] <= 1'b1;
                  if (pending[i] && !ack[i])
                     overrun[i] <= 1'b1;
               end else if (ack[i]) begin
                  pending[i] <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler
//   Bench for tick_scheduler with NCH=3, AW=2, CW=8. A behavioural model counts
//   active cycles since each channel's last write and ticks whenever that count
//   is a multiple of the period; a compare process checks every output on every
//   falling edge. Directed scenarios add literal expectations.
module tb_tick_scheduler;

   localparam int NCH = 3;
   localparam int AW  = 2;
   localparam int CW  = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cfg_we;
   logic [AW-1:0]   cfg_addr;
   logic [CW-1:0]   cfg_period;
   logic            cfg_en;
   logic            pause;
   logic [NCH-1:0]  ack;
   logic [NCH-1:0]  tick;
   logic [NCH-1:0]  pending;
   logic [NCH-1:0]  overrun;
   logic [CW-1:0]   free_cnt;

   int total = 0;
   int bad   = 0;

   tick_scheduler #(.NCH(NCH), .AW(AW), .CW(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_period (cfg_period),
      .cfg_en     (cfg_en),
      .pause      (pause),
      .ack        (ack),
      .tick       (tick),
      .pending    (pending),
      .overrun    (overrun),
      .free_cnt   (free_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural model
   logic [NCH-1:0] m_tick = '0;
   logic [NCH-1:0] m_pend = '0;
   logic [NCH-1:0] m_ovr  = '0;
   logic [NCH-1:0] m_en   = '0;
   logic [CW-1:0]  m_free = '0;
   int             m_per [NCH];
   int             m_act [NCH];

   initial begin
      for (int c = 0; c < NCH; c++) begin
         m_per[c] = 0;
         m_act[c] = 0;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_tick = '0;
            m_pend = '0;
            m_ovr  = '0;
            m_en   = '0;
            m_free = '0;
            for (int c = 0; c < NCH; c++) begin
               m_per[c] = 0;
               m_act[c] = 0;
            end
         end else begin
            m_free = m_free + 8'd1;
            for (int c = 0; c < NCH; c++) begin
               if (cfg_we && cfg_addr == 2'(c)) begin
                  m_per[c]  = int'(cfg_period);
                  m_en[c]   = cfg_en;
                  m_act[c]  = 0;
                  m_tick[c] = 1'b0;
                  m_pend[c] = 1'b0;
                  m_ovr[c]  = 1'b0;
               end else begin
                  logic ev;
                  ev = 1'b0;
                  if (m_en[c] && m_per[c] != 0 && !pause) begin
                     m_act[c] = m_act[c] + 1;
                     ev = ((m_act[c] % m_per[c]) == 0);
                  end
                  m_tick[c] = ev;
                  if (ev) begin
                     if (m_pend[c] && !ack[c]) m_ovr[c] = 1'b1;
                     m_pend[c] = 1'b1;
                  end else if (ack[c]) begin
                     m_pend[c] = 1'b0;
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every falling edge
   initial begin
      forever begin
         @(negedge clk);
         chk("tick",     int'(tick),     int'(m_tick));
         chk("pending",  int'(pending),  int'(m_pend));
         chk("overrun",  int'(overrun),  int'(m_ovr));
         chk("free_cnt", int'(free_cnt), int'(m_free));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int p, input int e);
      cfg_we     = 1'b1;
      cfg_addr   = 2'(a);
      cfg_period = 8'(p);
      cfg_en     = e[0];
      step();
      cfg_we     = 1'b0;
   endtask

   initial begin
      bit found;
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_period = '0;
      cfg_en = 1'b0; pause = 1'b0; ack = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_free", int'(free_cnt), 0);
      rst_n = 1'b1;
      step(); chk("rel_free1", int'(free_cnt), 1);
      step(); chk("rel_free2", int'(free_cnt), 2);

      // Period 5 on channel 0
      wr(0, 5, 1);
      for (int j = 1; j <= 15; j++) begin
         step();
         chk("p5_tick0", int'(tick[0]), int'(j % 5 == 0));
         chk("p5_others", int'(tick[2:1]), 0);
      end
      wr(0, 0, 0);

      // Pause mid-count on channel 1
      wr(1, 4, 1);
      step(); step();
      pause = 1'b1;
      repeat (6) begin
         step();
         chk("pause_tick1", int'(tick[1]), 0);
      end
      pause = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         step();
         chk("resume_tick1", int'(tick[1]), int'(j % 4 == 2));
      end
      wr(1, 0, 0);

      // Pending and overrun on channel 2
      wr(2, 3, 1);
      repeat (3) step();
      chk("pend_first", int'(pending[2]), 1);
      chk("ovr_first",  int'(overrun[2]), 0);
      repeat (3) step();
      chk("pend_second", int'(pending[2]), 1);
      chk("ovr_second",  int'(overrun[2]), 1);
      wr(2, 3, 1);
      chk("pend_cleared", int'(pending[2]), 0);
      chk("ovr_cleared",  int'(overrun[2]), 0);

      // Ack coincident with a tick event, then ack alone
      repeat (3) step();
      chk("pend_w3", int'(pending[2]), 1);
      repeat (2) step();
      ack = 3'b100;
      step();
      chk("same_tick", int'(tick[2]), 1);
      chk("same_pend", int'(pending[2]), 1);
      chk("same_ovr",  int'(overrun[2]), 0);
      step();
      chk("ack_pend", int'(pending[2]), 0);
      ack = '0;
      wr(2, 0, 0);

      // Period 1, period 0, out-of-range address, free_cnt wrap
      wr(0, 1, 1);
      for (int j = 1; j <= 5; j++) begin
         step();
         chk("p1_tick0", int'(tick[0]), 1);
      end
      wr(1, 0, 1);
      repeat (6) begin
         step();
         chk("p0_tick1", int'(tick[1]), 0);
      end
      wr(3, 2, 1);
      chk("addr3_tick0", int'(tick[0]), 1);
      repeat (4) begin
         step();
         chk("addr3_quiet", int'(tick[2:1]), 0);
      end
      found = 1'b0;
      for (int j = 0; j < 300; j++) begin
         if (free_cnt == 8'hFF) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk("wrap_reached", int'(found), 1);
      step();
      chk("wrap_zero", int'(free_cnt), 0);

      // Asynchronous reset mid-run
      wr(2, 2, 1);
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      chk("arst_tick",    int'(tick),     0);
      chk("arst_pending", int'(pending),  0);
      chk("arst_overrun", int'(overrun),  0);
      chk("arst_free",    int'(free_cnt), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(); chk("arst_free1", int'(free_cnt), 1);
      step(); chk("arst_free2", int'(free_cnt), 2);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         cfg_we     = ($urandom_range(0, 19) == 0);
         cfg_addr   = 2'($urandom_range(0, 3));
         cfg_period = 8'($urandom_range(0, 6));
         cfg_en     = ($urandom_range(0, 3) != 0);
         pause      = ($urandom_range(0, 9) == 0);
         ack        = 3'($urandom);
         step();
      end
      cfg_we = 1'b0; pause = 1'b0; ack = '0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
